// File: rtl/vr_fifo_32.sv
// ----------------------------------------------------------------------------
// vr_fifo_32 - 32-bit valid/ready FIFO with fully registered handshake flags.
//
// Both ready_o and valid_o come straight from flops, so there is no
// combinational path from the upstream side (valid_i/data_i) to the
// downstream side (valid_o/data_o), nor from ready_i back to ready_o.
// count is the single source of truth for full/empty; the pointers are
// never compared against each other.
//
// Parameters:
//   DEPTH     number of 32-bit entries (power of 2, >= 2)
//   AF_LEVEL  almost-full threshold (1..DEPTH), only with the macro below
//
// Optional feature macro: VR_FIFO_ALMOST_FULL_EN
//   defined   -> almost_full_o port exists, registered (count_next >= AF_LEVEL)
//   undefined -> no almost_full_o port, AF_LEVEL ignored
//
// Ports:
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   flush_i        in   synchronous clear of all contents (wins over push/pop)
//   valid_i        in   upstream data valid
//   data_i   [31:0] in  upstream data
//   ready_o        out  FIFO can accept data (registered)
//   valid_o        out  head entry valid (registered)
//   data_o   [31:0] out head entry data, 0 when valid_o is low
//   ready_i        in   downstream accepts head entry
//   count_o        out  number of entries held, 0..DEPTH
//   almost_full_o  out  registered almost-full flag (macro only)
// ----------------------------------------------------------------------------
module vr_fifo_32 #(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic [31:0]              data_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [31:0]              data_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef VR_FIFO_ALMOST_FULL_EN
    ,
    output logic                     almost_full_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Elaboration-time parameter legality checks
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vr_fifo_32: DEPTH must be a power of 2 and at least 2");
    end
`ifdef VR_FIFO_ALMOST_FULL_EN
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
        $error("vr_fifo_32: AF_LEVEL must be in 1..DEPTH");
    end
`endif

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             push_s;
    logic             pop_s;

    // Handshakes use the registered flags, never the raw neighbour signals
    assign push_s = valid_i & ready_q;
    assign pop_s  = valid_q & ready_i;

    // Next-state for pointers, occupancy and the registered flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d != CNT_W'(DEPTH));
        valid_d = (count_d != {CNT_W{1'b0}});
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Storage write; not reset, and a flush drops the same-cycle push
    always_ff @(posedge clk) begin
        if (push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // The head slot cannot be overwritten while valid (a push needs count < DEPTH),
    // so data_o stays stable until it is popped.
    assign data_o  = valid_q ? mem_q[rd_ptr_q] : 32'h0;
    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

`ifdef VR_FIFO_ALMOST_FULL_EN
    logic af_q, af_d;

    // Almost-full flag looks ahead at the next occupancy like the other flags
    always_comb begin
        af_d = (count_d >= CNT_W'(AF_LEVEL));
    end

    // Almost-full flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign almost_full_o = af_q;
`endif

endmodule

// File: tb/tb_vr_fifo_32.sv
// ----------------------------------------------------------------------------
// Self-checking bench for vr_fifo_32 (DEPTH=4, AF_LEVEL=3).
// A queue holds the words the bench expects to see: pushed when a push
// handshake is predicted, popped when a pop handshake is predicted.
// Outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_vr_fifo_32;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset_n;
    logic          flush_i;
    logic          valid_i;
    logic [31:0]   data_i;
    logic          ready_o;
    logic          valid_o;
    logic [31:0]   data_o;
    logic          ready_i;
    logic [CW-1:0] count_o;
`ifdef VR_FIFO_ALMOST_FULL_EN
    logic          almost_full_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    vr_fifo_32 #(.DEPTH(DEPTH), .AF_LEVEL(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .count_o (count_o)
`ifdef VR_FIFO_ALMOST_FULL_EN
        ,
        .almost_full_o (almost_full_o)
`endif
    );

    // {valid_o, ready_o, count_o, data_o}
    logic [36:0] obs_s;
    assign obs_s = {valid_o, ready_o, count_o, data_o};

    always #5 clk = ~clk;

    // Expected output bundle derived from the scoreboard queue
    function automatic logic [36:0] model_out();
        int n;
        logic [31:0] hd;
        n  = exp_q.size();
        hd = (n != 0) ? exp_q[0] : 32'h0;
        return {(n != 0), (n != DEPTH), 3'(n), hd};
    endfunction

    // Drive one cycle of stimulus, predict the handshakes, advance the clock
    task automatic tick(input logic v, input logic [31:0] d, input logic r, input logic f);
        bit push, pop;
        logic [31:0] tmp;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        push = v && (exp_q.size() != DEPTH);
        pop  = r && (exp_q.size() != 0);
        if (f) begin
            exp_q.delete();
        end else begin
            if (pop) tmp = exp_q.pop_front();
            if (push) exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        clk = 1'b0; reset_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = 32'h0;
        #12;
        n_tests++;
        if (obs_s !== {1'b0, 1'b1, 3'd0, 32'h0}) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs_s, {1'b0, 1'b1, 3'd0, 32'h0});
        end
`ifdef VR_FIFO_ALMOST_FULL_EN
        n_tests++;
        if (almost_full_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_af: got %b expected 0", almost_full_o);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (obs_s !== {1'b0, 1'b1, 3'd0, 32'h0}) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", obs_s, {1'b0, 1'b1, 3'd0, 32'h0});
        end
    endtask

    task automatic test_first_word();
        tick(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        n_tests++;
        if (obs_s !== {1'b1, 1'b1, 3'd1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL first_word: got %h expected %h", obs_s, {1'b1, 1'b1, 3'd1, 32'hDEADBEEF});
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (obs_s !== model_out()) begin
            n_fail++; $display("FAIL first_word_drain: got %h expected %h", obs_s, model_out());
        end
    endtask

    task automatic test_full();
        logic [31:0] drain_exp [4];
        drain_exp = '{32'h2, 32'h3, 32'h4, 32'h5};
        for (int i = 1; i <= 4; i++) tick(1'b1, 32'(i), 1'b0, 1'b0);
        n_tests++;
        if (obs_s !== {1'b1, 1'b0, 3'd4, 32'h1}) begin
            n_fail++; $display("FAIL full_after_4: got %h expected %h", obs_s, {1'b1, 1'b0, 3'd4, 32'h1});
        end
        tick(1'b1, 32'h5, 1'b0, 1'b0);
        n_tests++;
        if (obs_s !== {1'b1, 1'b0, 3'd4, 32'h1}) begin
            n_fail++; $display("FAIL full_hold: got %h expected %h", obs_s, {1'b1, 1'b0, 3'd4, 32'h1});
        end
        // Pop while full: no same-cycle push
        tick(1'b1, 32'h5, 1'b1, 1'b0);
        n_tests++;
        if (obs_s !== {1'b1, 1'b1, 3'd3, 32'h2}) begin
            n_fail++; $display("FAIL full_pop: got %h expected %h", obs_s, {1'b1, 1'b1, 3'd3, 32'h2});
        end
        tick(1'b1, 32'h5, 1'b0, 1'b0);
        n_tests++;
        if (obs_s !== {1'b1, 1'b0, 3'd4, 32'h2}) begin
            n_fail++; $display("FAIL full_refill: got %h expected %h", obs_s, {1'b1, 1'b0, 3'd4, 32'h2});
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (valid_o !== 1'b1 || data_o !== drain_exp[k] || obs_s !== model_out()) begin
                n_fail++; $display("FAIL full_drain[%0d]: got %h expected data %h", k, obs_s, drain_exp[k]);
            end
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_tests++;
        if (obs_s !== {1'b0, 1'b1, 3'd0, 32'h0}) begin
            n_fail++; $display("FAIL full_empty: got %h expected %h", obs_s, {1'b0, 1'b1, 3'd0, 32'h0});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 32'(i), 1'b1, 1'b0);
            n_tests++;
            if (obs_s !== {1'b1, 1'b1, 3'd1, 32'(i)} || obs_s !== model_out()) begin
                n_fail++; $display("FAIL stream[%0d]: got %h expected %h", i, obs_s, {1'b1, 1'b1, 3'd1, 32'(i)});
            end
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (obs_s !== {1'b0, 1'b1, 3'd0, 32'h0}) begin
            n_fail++; $display("FAIL stream_end: got %h expected %h", obs_s, {1'b0, 1'b1, 3'd0, 32'h0});
        end
    endtask

    task automatic test_flush();
        tick(1'b1, 32'h10, 1'b0, 1'b0);
        tick(1'b1, 32'h11, 1'b0, 1'b0);
        tick(1'b1, 32'h12, 1'b0, 1'b0);
        n_tests++;
        if (obs_s !== {1'b1, 1'b1, 3'd3, 32'h10}) begin
            n_fail++; $display("FAIL flush_pre: got %h expected %h", obs_s, {1'b1, 1'b1, 3'd3, 32'h10});
        end
        tick(1'b1, 32'hAA, 1'b1, 1'b1);
        n_tests++;
        if (obs_s !== {1'b0, 1'b1, 3'd0, 32'h0}) begin
            n_fail++; $display("FAIL flush_clear: got %h expected %h", obs_s, {1'b0, 1'b1, 3'd0, 32'h0});
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            n_tests++;
            if (obs_s !== {1'b0, 1'b1, 3'd0, 32'h0}) begin
                n_fail++; $display("FAIL flush_idle[%0d]: got %h expected %h", k, obs_s, {1'b0, 1'b1, 3'd0, 32'h0});
            end
        end
        tick(1'b1, 32'h33, 1'b0, 1'b0);
        n_tests++;
        if (obs_s !== {1'b1, 1'b1, 3'd1, 32'h33}) begin
            n_fail++; $display("FAIL flush_after: got %h expected %h", obs_s, {1'b1, 1'b1, 3'd1, 32'h33});
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        tick(1'b1, 32'h21, 1'b0, 1'b0);
        tick(1'b1, 32'h22, 1'b0, 1'b0);
        n_tests++;
        if (obs_s !== {1'b1, 1'b1, 3'd2, 32'h21}) begin
            n_fail++; $display("FAIL arst_pre: got %h expected %h", obs_s, {1'b1, 1'b1, 3'd2, 32'h21});
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (obs_s !== {1'b0, 1'b1, 3'd0, 32'h0}) begin
            n_fail++; $display("FAIL arst_immediate: got %h expected %h", obs_s, {1'b0, 1'b1, 3'd0, 32'h0});
        end
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b1, 32'h77, 1'b0, 1'b0);
        tick(1'b1, 32'h78, 1'b0, 1'b0);
        n_tests++;
        if (obs_s !== {1'b1, 1'b1, 3'd2, 32'h77}) begin
            n_fail++; $display("FAIL arst_first_out: got %h expected %h", obs_s, {1'b1, 1'b1, 3'd2, 32'h77});
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            n_tests++;
            if (obs_s !== model_out()) begin
                n_fail++; $display("FAIL arst_drain[%0d]: got %h expected %h", k, obs_s, model_out());
            end
        end
    endtask

`ifdef VR_FIFO_ALMOST_FULL_EN
    task automatic test_almost_full();
        logic af_exp [3];
        af_exp = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 32'(i + 100), 1'b0, 1'b0);
            n_tests++;
            if (almost_full_o !== af_exp[i]) begin
                n_fail++; $display("FAIL af_push[%0d]: got %b expected %b", i, almost_full_o, af_exp[i]);
            end
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (almost_full_o !== 1'b0 || count_o !== 3'd2) begin
            n_fail++; $display("FAIL af_pop: got af=%b count=%0d expected af=0 count=2", almost_full_o, count_o);
        end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_first_word();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef VR_FIFO_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
